// File: rtl/sig_defs.sv
// Shared lamp, phase and fault encodings for the signal controller and its monitor.
package sig_defs;

    typedef enum logic [1:0] {
        GREEN    = 2'd0,
        YELLOW   = 2'd1,
        RED      = 2'd2,
        LAMP_BAD = 2'd3
    } lamp_e;

    typedef enum logic [2:0] {
        S0     = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4,
        PH_INV = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_INVALID  = 3'd1,
        FLT_CONFLICT = 3'd2,
        FLT_ILLEGAL  = 3'd3,
        FLT_SHORT_Y  = 3'd4,
        FLT_SHORT_AR = 3'd5
    } fault_e;

    localparam int NUM_LAMPS = 2;

    typedef struct packed {
        logic invalid;
        logic illegal_step;
        logic y_to_r;
        logic r_to_g;
    } lamp_chk_t;

    function automatic logic [2:0] decode_phase(input logic [1:0] h, input logic [1:0] c);
        if (h == GREEN  && c == RED)    return S0;
        if (h == YELLOW && c == RED)    return S1;
        if (h == RED    && c == RED)    return S2;
        if (h == RED    && c == GREEN)  return S3;
        if (h == RED    && c == YELLOW) return S4;
        return PH_INV;
    endfunction

endpackage

// File: rtl/lamp_check.sv
// Per-lamp step classifier: flags invalid codes, illegal steps and the
// two transitions that carry dwell requirements.
module lamp_check
    import sig_defs::*;
(
    input  logic [1:0] prev_code,
    input  logic [1:0] cur_code,
    output logic       invalid,
    output logic       illegal_step,
    output logic       y_to_r,
    output logic       r_to_g
);

    assign invalid      = (cur_code == LAMP_BAD);
    assign illegal_step = (prev_code == GREEN  && cur_code == RED)    ||
                          (prev_code == YELLOW && cur_code == GREEN)  ||
                          (prev_code == RED    && cur_code == YELLOW);
    assign y_to_r       = (prev_code == YELLOW && cur_code == RED);
    assign r_to_g       = (prev_code == RED    && cur_code == GREEN);

endmodule

// File: rtl/sig_monitor.sv
// Independent lamp-aspect monitor: decodes phase, checks legality and dwell,
// latches the first fault and requests flash until clear.
module sig_monitor
    import sig_defs::*;
#(
    parameter int unsigned MIN_YELLOW  = 3,
    parameter int unsigned MIN_ALL_RED = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic [2:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam int unsigned DWELL_MAX = (1 << CNT_W) - 1;

    if (MIN_YELLOW > DWELL_MAX || MIN_ALL_RED > DWELL_MAX) begin : g_bad_param
        $error("sig_monitor: MIN_YELLOW/MIN_ALL_RED exceed dwell counter range");
    end

    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_AR  = CNT_W'(MIN_ALL_RED);
    localparam logic [CNT_W-1:0] DW_SAT  = CNT_W'(DWELL_MAX);

    logic [1:0]       prev_hwy, prev_cntry;
    logic [CNT_W-1:0] dwell;

    // lamp 0 = highway, lamp 1 = country
    logic [NUM_LAMPS-1:0][1:0] prev_lamp, cur_lamp;
    lamp_chk_t [NUM_LAMPS-1:0] chk;

    assign prev_lamp = {prev_cntry, prev_hwy};
    assign cur_lamp  = {cntry, hwy};

    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_lamp
        lamp_check u_lamp_check (
            .prev_code    (prev_lamp[i]),
            .cur_code     (cur_lamp[i]),
            .invalid      (chk[i].invalid),
            .illegal_step (chk[i].illegal_step),
            .y_to_r       (chk[i].y_to_r),
            .r_to_g       (chk[i].r_to_g)
        );
    end

    logic       any_invalid, conflict, any_illegal, short_y, short_ar, pair_same;
    logic [2:0] viol_code;

    always_comb begin
        any_invalid = chk[0].invalid | chk[1].invalid;
        conflict    = (hwy != RED) && (cntry != RED);
        any_illegal = chk[0].illegal_step | chk[1].illegal_step;
        short_y     = (chk[0].y_to_r | chk[1].y_to_r) && (dwell < MIN_Y);
        // All-red dwell only matters when the previous aspect was R/R.
        short_ar    = (prev_hwy == RED) && (prev_cntry == RED) &&
                      (chk[0].r_to_g | chk[1].r_to_g) && (dwell < MIN_AR);
        pair_same   = (hwy == prev_hwy) && (cntry == prev_cntry);

        viol_code = FLT_NONE;
        if (any_invalid)      viol_code = FLT_INVALID;
        else if (conflict)    viol_code = FLT_CONFLICT;
        else if (any_illegal) viol_code = FLT_ILLEGAL;
        else if (short_y)     viol_code = FLT_SHORT_Y;
        else if (short_ar)    viol_code = FLT_SHORT_AR;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            prev_hwy   <= GREEN;
            prev_cntry <= RED;
            dwell      <= CNT_W'(1);
            phase      <= S0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else begin
            prev_hwy   <= hwy;
            prev_cntry <= cntry;
            dwell      <= pair_same ? ((dwell == DW_SAT) ? dwell : dwell + 1'b1) : CNT_W'(1);
            phase      <= decode_phase(hwy, cntry);
            if (!fault && viol_code != FLT_NONE) begin
                fault      <= 1'b1;
                fault_code <= viol_code;
            end
        end
    end

    assign flash = fault;

endmodule

// File: tb/tb_sig_monitor.sv
// Scoreboard bench for sig_monitor: a reference model pushes expected outputs
// per driven pair; they are popped and compared after each edge.
module tb_sig_monitor;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] hwy   = 2'd0;
    logic [1:0] cntry = 2'd2;
    logic [2:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    sig_monitor dut (
        .clock      (clock),
        .clear      (clear),
        .hwy        (hwy),
        .cntry      (cntry),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .flash      (flash)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ph;
        int flt;
        int code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_ph_lamp = 0, m_pc_lamp = 2, m_dwell = 1, m_fault = 0, m_code = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit step_ok(input int p, input int c);
        case ({p[1:0], c[1:0]})
            4'b0000, 4'b0001, 4'b0101, 4'b0110, 4'b1010, 4'b1000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_phase(input int h, input int c);
        case ({h[1:0], c[1:0]})
            4'b0010: return 0;
            4'b0110: return 1;
            4'b1010: return 2;
            4'b1000: return 3;
            4'b1001: return 4;
            default: return 7;
        endcase
    endfunction

    task automatic step(input int h, input int c, input bit clr = 1'b0);
        exp_t e;
        int   v;
        @(negedge clock);
        hwy   = 2'(h);
        cntry = 2'(c);
        clear = clr;
        if (clr) begin
            m_ph_lamp = 0; m_pc_lamp = 2; m_dwell = 1; m_fault = 0; m_code = 0;
            e.ph = 0;
        end else begin
            v = 0;
            if (h == 3 || c == 3)                          v = 1;
            else if (h != 2 && c != 2)                     v = 2;
            else if (!step_ok(m_ph_lamp, h) || !step_ok(m_pc_lamp, c)) v = 3;
            else if (((m_ph_lamp == 1 && h == 2) || (m_pc_lamp == 1 && c == 2)) && m_dwell < 3) v = 4;
            else if (m_ph_lamp == 2 && m_pc_lamp == 2 && (h == 0 || c == 0) && m_dwell < 2) v = 5;
            if (m_fault == 0 && v != 0) begin
                m_fault = 1;
                m_code  = v;
            end
            if (h == m_ph_lamp && c == m_pc_lamp) m_dwell = (m_dwell >= 15) ? 15 : m_dwell + 1;
            else                                  m_dwell = 1;
            m_ph_lamp = h;
            m_pc_lamp = c;
            e.ph = ref_phase(h, c);
        end
        e.flt  = m_fault;
        e.code = m_code;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk("phase", int'(phase), e.ph);
        chk("fault", int'(fault), e.flt);
        chk("fault_code", int'(fault_code), e.code);
        chk("flash", int'(flash), e.flt);
    endtask

    task automatic rep(input int h, input int c, input int n);
        for (int i = 0; i < n; i++) step(h, c);
    endtask

    initial begin
        // full legal cycle
        step(0, 2, 1'b1);
        chk("reset_phase", int'(phase), 0);
        chk("reset_fault", int'(fault), 0);
        rep(0, 2, 4); rep(1, 2, 3); rep(2, 2, 2); rep(2, 0, 5); rep(2, 1, 3); rep(0, 2, 2);
        chk("cycle_fault", int'(fault), 0);
        chk("cycle_phase", int'(phase), 0);

        // short yellow
        step(0, 2, 1'b1); rep(0, 2, 2); rep(1, 2, 2); step(2, 2);
        chk("short_y_code", int'(fault_code), 4);
        chk("short_y_phase", int'(phase), 2);
        chk("short_y_flash", int'(flash), 1);

        // invalid code, then later conflict must not overwrite it
        step(0, 2, 1'b1); step(3, 2);
        chk("invalid_code", int'(fault_code), 1);
        step(0, 0);
        chk("invalid_sticky", int'(fault_code), 1);

        // conflict and illegal transition
        step(0, 2, 1'b1); step(0, 2); step(0, 0);
        chk("conflict_code", int'(fault_code), 2);
        step(0, 2, 1'b1); step(0, 2); step(2, 2);
        chk("illegal_code", int'(fault_code), 3);

        // conflict outranks the simultaneous illegal R->Y step
        step(0, 2, 1'b1); step(0, 1);
        chk("prio_code", int'(fault_code), 2);

        // short all-red vs. adequate all-red
        step(0, 2, 1'b1); step(0, 2); rep(1, 2, 3); step(2, 2); step(0, 2);
        chk("short_ar_code", int'(fault_code), 5);

        // clear while faulted with illegal inputs: no check on that edge
        step(0, 0, 1'b1);
        chk("clear_fault", int'(fault), 0);
        chk("clear_phase", int'(phase), 0);
        step(0, 2);
        chk("post_clear_fault", int'(fault), 0);

        step(0, 2, 1'b1); step(0, 2); rep(1, 2, 3); rep(2, 2, 2); step(0, 2);
        chk("ok_ar_fault", int'(fault), 0);

        // dwell saturation: a long yellow must not wrap into a short one
        step(0, 2, 1'b1); step(0, 2); rep(1, 2, 16); step(2, 2);
        chk("sat_fault", int'(fault), 0);

        // random legal/illegal pairs against the model
        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 0) step(0, 2, 1'b1);
            else             step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
